// File: rtl/arashi_thread_fifo.sv
// arashi_thread_fifo
//   Per-thread first-word-fall-through FIFOs for the arashi datapath. Each of
//   THREAD_NUM threads owns an independent DEPTH-word buffer driven by its own
//   4-bit command slice of ctrl.
//
//   Ports
//     clk       in   sole clock, rising edge
//     rstn      in   asynchronous reset, active-high (1 = reset)
//     ctrl      in   per-thread command, thread i = [4i+3:4i]
//                    0 NOP, 1 WRITE, 2 READ, 3 WRITE+READ, 4 FLUSH, 8 CLR_ERR
//     data_in   in   write data, thread i = [DATA_WIDTH*i +: DATA_WIDTH]
//     w_ready   out  thread i not full
//     r_ready   out  thread i not empty
//     data_out  out  head word of thread i (zero when empty)
//     afull     out  thread i count >= AFULL_TH
//     count     out  fill level of thread i, CW bits per thread
//     err       out  sticky overflow/underflow flag per thread
//
//   All outputs decode registered state only; ctrl/data_in never reach an
//   output combinationally.

module arashi_thread_fifo #(
    parameter int THREAD_NUM = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AFULL_TH   = DEPTH - 2
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [THREAD_NUM*4-1:0]              ctrl,
    input  logic [DATA_WIDTH*THREAD_NUM-1:0]     data_in,
    output logic [THREAD_NUM-1:0]                w_ready,
    output logic [THREAD_NUM-1:0]                r_ready,
    output logic [DATA_WIDTH*THREAD_NUM-1:0]     data_out,
    output logic [THREAD_NUM-1:0]                afull,
    output logic [$clog2(DEPTH+1)*THREAD_NUM-1:0] count,
    output logic [THREAD_NUM-1:0]                err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [3:0] CMD_WRITE   = 4'h1;
    localparam logic [3:0] CMD_READ    = 4'h2;
    localparam logic [3:0] CMD_WR_RD   = 4'h3;
    localparam logic [3:0] CMD_FLUSH   = 4'h4;
    localparam logic [3:0] CMD_CLR_ERR = 4'h8;

    localparam logic [CW-1:0] COUNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_AFULL = CW'(AFULL_TH);

    for (genvar t = 0; t < THREAD_NUM; t++) begin : g_thread
        logic [3:0]            cmd;
        logic [DATA_WIDTH-1:0] wdata;

        logic [CW-1:0]         count_q, count_d;
        logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
        logic                  err_q, err_d;
        logic                  mem_we;
        logic                  empty, full;
        logic                  is_wr, is_rd, do_wr, do_rd;

        logic [DATA_WIDTH-1:0] mem_q [DEPTH];

        assign cmd   = ctrl[4*t +: 4];
        assign wdata = data_in[DATA_WIDTH*t +: DATA_WIDTH];

        // Full/empty come from the occupancy count so that a full FIFO and an
        // empty one are never confused when the pointers coincide.
        assign empty = (count_q == '0);
        assign full  = (count_q == COUNT_FULL);

        always_comb begin
            count_d  = count_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            err_d    = err_q;
            mem_we   = 1'b0;
            is_wr    = 1'b0;
            is_rd    = 1'b0;
            do_wr    = 1'b0;
            do_rd    = 1'b0;

            case (cmd)
                CMD_WRITE, CMD_READ, CMD_WR_RD: begin
                    is_wr = (cmd == CMD_WRITE) || (cmd == CMD_WR_RD);
                    is_rd = (cmd == CMD_READ)  || (cmd == CMD_WR_RD);
                    do_rd = is_rd && !empty;
                    // A full FIFO still takes the write when a slot frees in
                    // the same cycle.
                    do_wr = is_wr && (!full || do_rd);
                    if ((is_wr && !do_wr) || (is_rd && empty)) begin
                        err_d = 1'b1;
                    end
                    if (do_wr) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (do_rd) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                    count_d = count_q + CW'(do_wr) - CW'(do_rd);
                end
                CMD_FLUSH: begin
                    count_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
                CMD_CLR_ERR: begin
                    err_d = 1'b0;
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or posedge rstn) begin
            if (rstn) begin
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                err_q    <= 1'b0;
            end else begin
                count_q  <= count_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                err_q    <= err_d;
            end
        end

        // Storage is deliberately left out of reset; count gates its visibility.
        always_ff @(posedge clk) begin
            if (mem_we) begin
                mem_q[wr_ptr_q] <= wdata;
            end
        end

        assign w_ready[t]                             = !full;
        assign r_ready[t]                             = !empty;
        assign afull[t]                               = (count_q >= COUNT_AFULL);
        assign count[CW*t +: CW]                      = count_q;
        assign err[t]                                 = err_q;
        assign data_out[DATA_WIDTH*t +: DATA_WIDTH]   = empty ? '0 : mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_arashi_thread_fifo.sv
module tb_arashi_thread_fifo;

    localparam int TN = 4;
    localparam int DW = 32;
    localparam int DP = 8;
    localparam int CW = 4;

    logic              clk;
    logic              rstn;
    logic [TN*4-1:0]   ctrl;
    logic [DW*TN-1:0]  data_in;
    logic [TN-1:0]     w_ready;
    logic [TN-1:0]     r_ready;
    logic [DW*TN-1:0]  data_out;
    logic [TN-1:0]     afull;
    logic [CW*TN-1:0]  count;
    logic [TN-1:0]     err;

    int vectors;
    int miscompares;

    arashi_thread_fifo #(
        .THREAD_NUM (TN),
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .AFULL_TH   (DP - 2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .ctrl     (ctrl),
        .data_in  (data_in),
        .w_ready  (w_ready),
        .r_ready  (r_ready),
        .data_out (data_out),
        .afull    (afull),
        .count    (count),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ctrl    = '0;
        data_in = '0;
    endtask

    task automatic cmd(input int t, input logic [3:0] c, input logic [DW-1:0] d);
        ctrl[4*t +: 4]     = c;
        data_in[DW*t +: DW] = d;
    endtask

    function automatic logic [DW-1:0] dout(input int t);
        return data_out[DW*t +: DW];
    endfunction

    function automatic logic [CW-1:0] cnt(input int t);
        return count[CW*t +: CW];
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_w_ready"},  w_ready,  4'hF);
        chk({tag, "_r_ready"},  r_ready,  4'h0);
        chk({tag, "_afull"},    afull,    4'h0);
        chk({tag, "_count"},    count,    16'h0);
        chk({tag, "_err"},      err,      4'h0);
        chk({tag, "_data_out"}, data_out[63:0], 64'h0);
        chk({tag, "_data_hi"},  data_out[127:64], 64'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b1;
        idle();

        // power-up reset
        #23;
        chk_reset_values("por");
        @(negedge clk);
        rstn = 1'b0;
        #1;

        // thread 0: fill with 0x10..0x17
        for (int k = 0; k < 8; k++) begin
            idle();
            cmd(0, 4'h1, 32'h10 + k);
            tick();
            chk($sformatf("fill0_count_%0d", k), cnt(0), k + 1);
            chk($sformatf("fill0_afull_%0d", k), afull[0], (k + 1) >= 6);
            chk($sformatf("fill0_wready_%0d", k), w_ready[0], (k + 1) < 8);
            chk($sformatf("fill0_head_%0d", k), dout(0), 32'h10);
        end

        // thread 0: drain, data sampled in the READ cycle
        for (int k = 0; k < 8; k++) begin
            idle();
            chk($sformatf("drain0_data_%0d", k), dout(0), 32'h10 + k);
            cmd(0, 4'h2, 32'h0);
            tick();
            chk($sformatf("drain0_rready_%0d", k), r_ready[0], k < 7);
            chk($sformatf("drain0_count_%0d", k), cnt(0), 7 - k);
        end
        chk("drain0_empty_data", dout(0), 32'h0);
        chk("drain0_err", err[0], 1'b0);

        // fill threads 1 and 2 together
        for (int k = 0; k < 8; k++) begin
            idle();
            cmd(1, 4'h1, 32'h80 + k);
            cmd(2, 4'h1, 32'h20 + k);
            tick();
        end
        chk("fill12_count1", cnt(1), 8);
        chk("fill12_count2", cnt(2), 8);
        chk("fill12_wready", w_ready[2:1], 2'b00);

        // thread 1 overflow, then clear
        idle();
        cmd(1, 4'h1, 32'hAA);
        tick();
        chk("ovf1_err", err[1], 1'b1);
        chk("ovf1_count", cnt(1), 8);
        chk("ovf1_head", dout(1), 32'h80);
        chk("ovf1_others_err", {err[3:2], err[0]}, 3'b000);
        idle();
        cmd(1, 4'h8, 32'h0);
        tick();
        chk("clr1_err", err[1], 1'b0);
        chk("clr1_count", cnt(1), 8);

        // thread 2 full: sustained WRITE+READ across pointer wrap
        for (int k = 0; k < 8; k++) begin
            idle();
            chk($sformatf("wr2_data_%0d", k), dout(2), 32'h20 + k);
            cmd(2, 4'h3, 32'h50 + k);
            tick();
            chk($sformatf("wr2_count_%0d", k), cnt(2), 8);
            chk($sformatf("wr2_err_%0d", k), err[2], 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            idle();
            chk($sformatf("wrap2_data_%0d", k), dout(2), 32'h50 + k);
            cmd(2, 4'h2, 32'h0);
            tick();
        end
        chk("wrap2_count", cnt(2), 0);
        chk("wrap2_rready", r_ready[2], 1'b0);

        // thread 3 underflow, then WRITE+READ on empty
        idle();
        cmd(3, 4'h2, 32'h0);
        tick();
        chk("udf3_err", err[3], 1'b1);
        chk("udf3_count", cnt(3), 0);
        idle();
        cmd(3, 4'h3, 32'h33);
        tick();
        chk("wrrd3_count", cnt(3), 1);
        chk("wrrd3_data", dout(3), 32'h33);
        chk("wrrd3_err", err[3], 1'b1);

        // thread 0 half full, then FLUSH alongside traffic on 1..3
        for (int k = 0; k < 4; k++) begin
            idle();
            cmd(0, 4'h1, 32'h40 + k);
            tick();
        end
        chk("half0_count", cnt(0), 4);
        chk("half0_afull", afull[0], 1'b0);
        idle();
        cmd(0, 4'h4, 32'hDEAD);
        cmd(1, 4'h2, 32'h0);
        cmd(2, 4'h1, 32'h99);
        cmd(3, 4'h1, 32'h34);
        tick();
        chk("flush0_count", cnt(0), 0);
        chk("flush0_rready", r_ready[0], 1'b0);
        chk("flush0_data", dout(0), 32'h0);
        chk("flush0_err", err[0], 1'b0);
        chk("flush_t1_count", cnt(1), 7);
        chk("flush_t1_data", dout(1), 32'h81);
        chk("flush_t2_count", cnt(2), 1);
        chk("flush_t2_data", dout(2), 32'h99);
        chk("flush_t3_count", cnt(3), 2);
        chk("flush_t3_data", dout(3), 32'h33);
        chk("flush_t3_err", err[3], 1'b1);

        // post-flush write lands at slot 0 and becomes head
        idle();
        cmd(0, 4'h1, 32'hC1);
        tick();
        chk("pf0_count", cnt(0), 1);
        chk("pf0_data", dout(0), 32'hC1);

        // mid-stream reset, asynchronous and between edges
        idle();
        #2;
        rstn = 1'b1;
        #1;
        chk_reset_values("mid");
        tick();
        chk_reset_values("mid_held");
        rstn = 1'b0;
        #1;

        // behaves as from power-up
        idle();
        cmd(0, 4'h1, 32'hC0);
        cmd(3, 4'h1, 32'hE3);
        tick();
        chk("pr_count0", cnt(0), 1);
        chk("pr_data0", dout(0), 32'hC0);
        chk("pr_data3", dout(3), 32'hE3);
        chk("pr_rready", r_ready, 4'b1001);
        chk("pr_count12", count[11:4], 8'h00);
        idle();
        cmd(0, 4'h2, 32'h0);
        tick();
        chk("pr_rd_count0", cnt(0), 0);
        chk("pr_rd_rready0", r_ready[0], 1'b0);
        chk("pr_rd_err", err, 4'h0);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
